// File: rtl/reset_sequencer.sv
// Purpose: synchronise PLL lock, hold it, then release NUM_OUTPUTS reset domains lowest index first.
// Latency: first release SYNC_STAGES+HOLD_CYCLES edges after stable lock, then one output per STAGGER_CYCLES.
// Backpressure: none; lock loss or a software request in RUN re-asserts every domain and is logged.
module reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int NUM_OUTPUTS     = 3,
    parameter int STAGGER_CYCLES  = 4,
    parameter int SW_RESET_CYCLES = 8,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   locked_async,
    input  logic                   sw_reset_req,
    output logic                   locked,
    output logic [NUM_OUTPUTS-1:0] resets_out,
    output logic                   ready,
    output logic [1:0]             cause,
    output logic [COUNT_WIDTH-1:0] event_count
);

    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_CNT = (MAX_HS > SW_RESET_CYCLES) ? MAX_HS : SW_RESET_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int STG_W   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_SWRST   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       counter_q, counter_d;
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [NUM_OUTPUTS-1:0] resets_q, resets_d;
    logic                   ready_q, ready_d;
    logic [1:0]             cause_q, cause_d;
    logic [COUNT_WIDTH-1:0] events_q, events_d;
    logic                   bump;

    // Lock synchroniser: plain shift chain, the last stage is the only one used by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};
        end
    end

    assign locked = sync_q[SYNC_STAGES-1];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ASSERT;
            counter_q <= '0;
            stage_q   <= '0;
            resets_q  <= '1;
            ready_q   <= 1'b0;
            cause_q   <= 2'd0;
            events_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            stage_q   <= stage_d;
            resets_q  <= resets_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
            events_q  <= events_d;
        end
    end

    // Next-state logic: hold count, staggered release, run monitoring, software hold.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        stage_d   = stage_q;
        resets_d  = resets_q;
        ready_d   = ready_q;
        cause_d   = cause_q;
        events_d  = events_q;
        bump      = 1'b0;

        if (state_q != ST_ASSERT && !locked) begin
            // Lock loss anywhere past the hold phase restarts the whole sequence.
            state_d   = ST_ASSERT;
            counter_d = '0;
            stage_d   = '0;
            resets_d  = '1;
            ready_d   = 1'b0;
            cause_d   = CAUSE_LOCK;
            bump      = 1'b1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    resets_d = '1;
                    ready_d  = 1'b0;
                    if (!locked) begin
                        counter_d = '0;
                    end else if (counter_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        counter_d = '0;
                        stage_d   = '0;
                        if (NUM_OUTPUTS == 1) begin
                            state_d  = ST_RUN;
                            resets_d = '0;
                            ready_d  = 1'b1;
                        end else begin
                            state_d  = ST_RELEASE;
                            resets_d = ~NUM_OUTPUTS'(1);
                        end
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (counter_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                        counter_d = '0;
                        stage_d   = stage_q + STG_W'(1);
                        // Shifting in a zero at the bottom drops the next-higher domain.
                        resets_d  = resets_q << 1;
                        if (stage_q == STG_W'(NUM_OUTPUTS - 2)) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    resets_d = '0;
                    ready_d  = 1'b1;
                    if (sw_reset_req) begin
                        state_d   = ST_SWRST;
                        counter_d = '0;
                        resets_d  = '1;
                        ready_d   = 1'b0;
                        cause_d   = CAUSE_SW;
                        bump      = 1'b1;
                    end
                end
                ST_SWRST: begin
                    resets_d = '1;
                    ready_d  = 1'b0;
                    if (counter_q == CNT_W'(SW_RESET_CYCLES - 1)) begin
                        // Back through ASSERT so the full lock hold is required again.
                        state_d   = ST_ASSERT;
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d   = ST_ASSERT;
                    counter_d = '0;
                    resets_d  = '1;
                    ready_d   = 1'b0;
                end
            endcase
        end

        if (bump && (events_q != '1)) begin
            events_d = events_q + COUNT_WIDTH'(1);
        end
    end

    assign resets_out  = resets_q;
    assign ready       = ready_q;
    assign cause       = cause_q;
    assign event_count = events_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: directed and randomised checks of reset_sequencer against a phase/elapsed-time model.
// Latency: model and DUTs advance on the same rising edge; outputs sampled on the falling edge.
// Backpressure: none; every wait is bounded by an explicit cycle limit.
module tb_reset_sequencer;

    localparam int S  = 2;
    localparam int H  = 16;
    localparam int N  = 3;
    localparam int ST = 4;
    localparam int SW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       locked_async = 1'b0;
    logic       sw_reset_req = 1'b0;

    logic       locked;
    logic [2:0] resets_out;
    logic       ready;
    logic [1:0] cause;
    logic [7:0] event_count;

    logic       s_locked;
    logic [2:0] s_resets_out;
    logic       s_ready;
    logic [1:0] s_cause;
    logic [1:0] s_event_count;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    reset_sequencer dut (
        .clk(clk), .reset(reset), .locked_async(locked_async), .sw_reset_req(sw_reset_req),
        .locked(locked), .resets_out(resets_out), .ready(ready), .cause(cause),
        .event_count(event_count)
    );

    reset_sequencer #(.COUNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .locked_async(locked_async), .sw_reset_req(sw_reset_req),
        .locked(s_locked), .resets_out(s_resets_out), .ready(s_ready), .cause(s_cause),
        .event_count(s_event_count)
    );

    // Reference model: phase 0 = holding, 1 = releasing, 2 = running, 3 = software hold;
    // m_t is the time spent in the current phase measured in edges.
    logic [S-1:0] m_hist;
    int           m_phase, m_t, m_cause, m_events;
    logic         m_lk;

    always @(posedge clk) begin
        if (reset) begin
            edge_n = 0; m_hist = '0; m_phase = 0; m_t = 0; m_cause = 0; m_events = 0;
        end else begin
            edge_n++;
            m_lk   = m_hist[S-1];
            m_hist = {m_hist[S-2:0], locked_async};
            if (m_phase != 0 && !m_lk) begin
                m_phase = 0; m_t = 0; m_cause = 1; m_events++;
            end else begin
                case (m_phase)
                    0: if (!m_lk) m_t = 0;
                       else begin
                           m_t++;
                           if (m_t == H) begin m_t = 0; m_phase = (N == 1) ? 2 : 1; end
                       end
                    1: begin m_t++; if (m_t == (N - 1) * ST) begin m_t = 0; m_phase = 2; end end
                    2: if (sw_reset_req) begin m_phase = 3; m_t = 0; m_cause = 2; m_events++; end
                    default: begin m_t++; if (m_t == SW) begin m_t = 0; m_phase = 0; end end
                endcase
            end
        end
    end

    function automatic logic [2:0] m_resets();
        logic [2:0] ones;
        ones = 3'b111;
        case (m_phase)
            1:       return ones << (1 + m_t / ST);
            2:       return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    task automatic do_reset(input logic la);
        @(negedge clk);
        reset = 1'b1; sw_reset_req = 1'b0; locked_async = la;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_edge(input int k);
        for (int i = 0; i < 1000 && edge_n < k; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; locked_async = 1'b1; sw_reset_req = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({locked, resets_out, ready, cause, event_count} !== {1'b0, 3'b111, 1'b0, 2'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_full: locked=%b resets=%b ready=%b cause=%0d count=%0d, want 0 111 0 0 0",
                     locked, resets_out, ready, cause, event_count);
        end
        checks++;
        if ({s_locked, s_resets_out, s_ready, s_cause, s_event_count} !== {1'b0, 3'b111, 1'b0, 2'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_sat: locked=%b resets=%b ready=%b cause=%0d count=%0d, want 0 111 0 0 0",
                     s_locked, s_resets_out, s_ready, s_cause, s_event_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_startup();
        logic [2:0] er;
        do_reset(1'b1);
        for (int n = 1; n <= 30; n++) begin
            wait_edge(n);
            er = (n < 18) ? 3'b111 : (n < 22) ? 3'b110 : (n < 26) ? 3'b100 : 3'b000;
            checks++;
            if (locked !== (n >= 2) || resets_out !== er || ready !== (n >= 26) || cause !== 2'd0) begin
                errors++;
                $display("FAIL startup edge %0d: locked=%b resets=%b ready=%b cause=%0d, want %b %b %b 0",
                         n, locked, resets_out, ready, cause, n >= 2, er, n >= 26);
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] er;
        do_reset(1'b1);
        wait_edge(9);
        locked_async = 1'b0;
        wait_edge(10);
        locked_async = 1'b1;
        for (int n = 10; n <= 36; n++) begin
            wait_edge(n);
            er = (n < 28) ? 3'b111 : (n < 32) ? 3'b110 : (n < 36) ? 3'b100 : 3'b000;
            checks++;
            if (locked !== (n != 11) || resets_out !== er || ready !== (n >= 36)) begin
                errors++;
                $display("FAIL glitch edge %0d: locked=%b resets=%b ready=%b, want %b %b %b",
                         n, locked, resets_out, ready, n != 11, er, n >= 36);
            end
        end
    endtask

    task automatic test_lock_loss();
        do_reset(1'b1);
        wait_edge(40);
        locked_async = 1'b0;
        wait_edge(41);
        checks++;
        if (locked !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL loss_e41: locked=%b ready=%b, want 1 1", locked, ready);
        end
        wait_edge(42);
        checks++;
        if (locked !== 1'b0 || ready !== 1'b1 || resets_out !== 3'b000) begin
            errors++; $display("FAIL loss_e42: locked=%b ready=%b resets=%b, want 0 1 000", locked, ready, resets_out);
        end
        wait_edge(43);
        locked_async = 1'b1;
        checks++;
        if (resets_out !== 3'b111 || ready !== 1'b0 || cause !== 2'd1 || event_count !== 8'd1) begin
            errors++;
            $display("FAIL loss_e43: resets=%b ready=%b cause=%0d count=%0d, want 111 0 1 1",
                     resets_out, ready, cause, event_count);
        end
        wait_edge(60);
        checks++;
        if (resets_out !== 3'b111) begin
            errors++; $display("FAIL relock_e60: resets=%b, want 111", resets_out);
        end
        wait_edge(61);
        checks++;
        if (resets_out !== 3'b110) begin
            errors++; $display("FAIL relock_e61: resets=%b, want 110", resets_out);
        end
        wait_edge(65);
        checks++;
        if (resets_out !== 3'b100) begin
            errors++; $display("FAIL relock_e65: resets=%b, want 100", resets_out);
        end
        wait_edge(69);
        checks++;
        if (resets_out !== 3'b000 || ready !== 1'b1 || cause !== 2'd1) begin
            errors++; $display("FAIL relock_e69: resets=%b ready=%b cause=%0d, want 000 1 1", resets_out, ready, cause);
        end
    endtask

    task automatic test_sw_reset();
        do_reset(1'b1);
        wait_edge(30);
        sw_reset_req = 1'b1;
        wait_edge(31);
        sw_reset_req = 1'b0;
        checks++;
        if (resets_out !== 3'b111 || ready !== 1'b0 || cause !== 2'd2 || event_count !== 8'd1) begin
            errors++;
            $display("FAIL sw_e31: resets=%b ready=%b cause=%0d count=%0d, want 111 0 2 1",
                     resets_out, ready, cause, event_count);
        end
        wait_edge(38);
        checks++;
        if (resets_out !== 3'b111) begin
            errors++; $display("FAIL sw_e38: resets=%b, want 111", resets_out);
        end
        wait_edge(54);
        checks++;
        if (resets_out !== 3'b111) begin
            errors++; $display("FAIL sw_e54: resets=%b, want 111", resets_out);
        end
        wait_edge(55);
        checks++;
        if (resets_out !== 3'b110) begin
            errors++; $display("FAIL sw_e55: resets=%b, want 110", resets_out);
        end
        wait_edge(63);
        checks++;
        if (resets_out !== 3'b000 || ready !== 1'b1 || cause !== 2'd2) begin
            errors++; $display("FAIL sw_e63: resets=%b ready=%b cause=%0d, want 000 1 2", resets_out, ready, cause);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        wait_edge(30);
        locked_async = 1'b0;
        wait_edge(32);
        sw_reset_req = 1'b1;
        wait_edge(33);
        sw_reset_req = 1'b0;
        locked_async = 1'b1;
        checks++;
        if (resets_out !== 3'b111 || cause !== 2'd1 || event_count !== 8'd1) begin
            errors++;
            $display("FAIL both_events: resets=%b cause=%0d count=%0d, want 111 1 1", resets_out, cause, event_count);
        end
        wait_edge(50);
        sw_reset_req = 1'b1;
        wait_edge(55);
        checks++;
        if (resets_out !== 3'b100 || cause !== 2'd1 || event_count !== 8'd1) begin
            errors++;
            $display("FAIL sw_in_release: resets=%b cause=%0d count=%0d, want 100 1 1", resets_out, cause, event_count);
        end
        wait_edge(59);
        checks++;
        if (resets_out !== 3'b000 || ready !== 1'b1) begin
            errors++; $display("FAIL sw_held_run: resets=%b ready=%b, want 000 1", resets_out, ready);
        end
        wait_edge(60);
        sw_reset_req = 1'b0;
        checks++;
        if (resets_out !== 3'b111 || ready !== 1'b0 || cause !== 2'd2 || event_count !== 8'd2) begin
            errors++;
            $display("FAIL sw_held_trigger: resets=%b ready=%b cause=%0d count=%0d, want 111 0 2 2",
                     resets_out, ready, cause, event_count);
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b1);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
            checks++;
            if (ready !== 1'b1) begin
                errors++; $display("FAIL sat_wait_ready event %0d: ready=%b, want 1", k, ready);
            end
            locked_async = 1'b0;
            for (int i = 0; i < 10 && ready !== 1'b0; i++) @(negedge clk);
            locked_async = 1'b1;
            checks++;
            if (event_count !== 8'(k) || s_event_count !== 2'((k > 3) ? 3 : k) || s_cause !== 2'd1) begin
                errors++;
                $display("FAIL sat_count event %0d: count=%0d sat_count=%0d sat_cause=%0d, want %0d %0d 1",
                         k, event_count, s_event_count, s_cause, k, (k > 3) ? 3 : k);
            end
        end
        for (int i = 0; i < 100 && resets_out !== 3'b110; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({locked, resets_out, ready, cause, event_count, s_resets_out, s_event_count}
                !== {1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid_release: locked=%b resets=%b ready=%b cause=%0d count=%0d sat_resets=%b sat_count=%0d, want 0 111 0 0 0 111 0",
                     locked, resets_out, ready, cause, event_count, s_resets_out, s_event_count);
        end
    endtask

    task automatic test_random();
        logic [23:0] act, exp;
        int          c8;
        do_reset(1'b1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            c8  = (m_events > 255) ? 255 : m_events;
            act = {locked, resets_out, ready, cause, event_count,
                   s_locked, s_resets_out, s_ready, s_cause, s_event_count};
            exp = {m_hist[S-1], m_resets(), m_phase == 2, 2'(m_cause), 8'(c8),
                   m_hist[S-1], m_resets(), m_phase == 2, 2'(m_cause), 2'((m_events > 3) ? 3 : m_events)};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: outputs=%h, want %h", cyc, act, exp);
            end
            reset        = ($urandom_range(0, 999) == 0);
            sw_reset_req = ($urandom_range(0, 24) == 0);
            if (locked_async) locked_async = ($urandom_range(0, 59) != 0);
            else              locked_async = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_glitch();
        test_lock_loss();
        test_sw_reset();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output PLL-lock reset generator in the top level.
- Synchronises an asynchronous lock signal and requires it to stay high for a programmable hold period.
- Releases NUM_OUTPUTS reset domains in a staggered order, lowest index first.
- Re-enters reset on lock loss or on a software reset request, and records the cause and the event count for firmware.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the lock synchroniser chain; must be >= 2.
- HOLD_CYCLES, 16, consecutive synchronised-locked cycles required before the first release; must be >= 1.
- NUM_OUTPUTS, 3, number of reset outputs; must be >= 1.
- STAGGER_CYCLES, 4, cycles between successive output releases; must be >= 1.
- SW_RESET_CYCLES, 8, cycles all outputs are held asserted after a software request; must be >= 1.
- COUNT_WIDTH, 8, width of the saturating reset-event counter.

Ports:
- clk, input, 1, single clock (PLL output domain).
- reset, input, 1, synchronous, active-high global reset.
- locked_async, input, 1, asynchronous PLL lock indication.
- sw_reset_req, input, 1, single-cycle or level request for a software reset.
- locked, output, 1, synchronised lock (last stage of the synchroniser chain).
- resets_out, output, NUM_OUTPUTS, active-high domain resets.
- ready, output, 1, high only when every resets_out bit is low.
- cause, output, 2, cause of the last reset: 0 = external/power-on, 1 = lock loss, 2 = software; 3 is unused.
- event_count, output, COUNT_WIDTH, count of lock-loss and software reset events.

Behaviour:
- All outputs are registered.
- Reset values (while reset is high):
  - synchroniser chain all 0, locked = 0;
  - state = ASSERT, counter = 0, stage = 0;
  - resets_out = all ones, ready = 0, cause = 0, event_count = 0.
- reset asserted mid-operation returns to these values on the next edge, regardless of state.
- Initial register values equal the reset values.
- Counter widths are $clog2 of max(HOLD_CYCLES, STAGGER_CYCLES, SW_RESET_CYCLES) + 1, with no wrap inside any state.
- ASSERT:
  - resets_out all ones, ready = 0.
  - If locked = 1, counter increments; if locked = 0, counter clears.
  - When locked = 1 and counter == HOLD_CYCLES-1: go to RELEASE, clear counter, stage = 0, resets_out[0] goes low.
- RELEASE:
  - Counter increments every edge.
  - When counter == STAGGER_CYCLES-1: clear counter, stage++, and resets_out[stage] goes low.
  - When the last bit goes low, go to RUN and assert ready on the same edge.
  - If NUM_OUTPUTS == 1, ASSERT goes directly to RUN: resets_out[0] low and ready high together.
  - Deasserted bits stay low while remaining in RELEASE.
- RUN:
  - resets_out all zero, ready = 1.
  - If locked = 0: go to ASSERT, cause = 1.
  - Else if sw_reset_req = 1: go to SWRST, cause = 2.
  - Either event increments event_count, saturating at all ones.
  - Lock loss wins if both events occur on the same edge.
- SWRST:
  - resets_out all ones, ready = 0.
  - Counter increments; when counter == SW_RESET_CYCLES-1, go to ASSERT with counter = 0, so the full hold is required again.
- Lock loss in RELEASE or SWRST:
  - go to ASSERT on the next edge, all outputs reasserted, counter cleared;
  - cause = 1, event_count increments.
- sw_reset_req is ignored outside RUN, and a level held high re-triggers only after RUN is reached again.
- Absolute timing, with edge n being the nth rising edge after reset falls and locked_async held high:
  - locked is high after edge SYNC_STAGES;
  - resets_out[i] falls after edge SYNC_STAGES + HOLD_CYCLES + i*STAGGER_CYCLES;
  - ready rises with the last output.

Test Plan:
- Defaults, locked_async = 1 from reset release -> locked high after edge 2; resets_out = 3'b110 after edge 18, 3'b100 after edge 22, 3'b000 with ready = 1 after edge 26; cause = 0.
- locked_async glitches low for 1 cycle at edge 10 during ASSERT -> hold counter restarts, first release is delayed by exactly the glitch-induced restart, and no output toggles early.
- In RUN, drop locked_async at edge 40 -> locked low after edge 42; all resets high and ready low after edge 43; cause = 1; event_count = 1; on relock the full 16+4+4 sequence repeats.
- In RUN, pulse sw_reset_req for 1 cycle -> outputs all high for 8 cycles in SWRST, then ASSERT hold of 16, then staggered release; cause = 2; event_count increments.
- sw_reset_req and lock loss on the same edge in RUN -> cause = 1, event_count +1 only; sw_reset_req held high during RELEASE -> no effect until RUN.
- COUNT_WIDTH = 2, five lock-loss events -> event_count saturates at 3; reset pulse mid-RELEASE -> all outputs return to reset values on the next edge.
